// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and state type for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  // funct3 encodings of the RV32M ops
  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_MULHU  = 3'd3;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_DIVU   = 3'd5;
  localparam logic [2:0] F_REM    = 3'd6;
  localparam logic [2:0] F_REMU   = 3'd7;

  // Iteration FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

  // rs1 is interpreted as signed for MULH, MULHSU, DIV and REM
  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == F_MULH) || (f3 == F_MULHSU) || (f3 == F_DIV) || (f3 == F_REM);
  endfunction

  // rs2 is interpreted as signed for MULH, DIV and REM (MULHSU takes it unsigned)
  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == F_MULH) || (f3 == F_DIV) || (f3 == F_REM);
  endfunction

endpackage

// File: rtl/muldiv_special.sv
// Detects divide cases whose result is fixed by the ISA (divide by zero, signed
// overflow) so the unit can skip the 32-cycle iteration for them.
module muldiv_special
  import muldiv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  output logic        hit_o,
  output logic [31:0] value_o
);

  // Special-case detection and the result it forces
  always_comb begin
    hit_o   = 1'b0;
    value_o = '0;
    if (funct3_i[2]) begin
      if (opb_i == '0) begin
        // Divide by zero: quotient all ones, remainder is the dividend
        hit_o   = 1'b1;
        value_o = funct3_i[1] ? opa_i : ALL_ONES;
      end else if (((funct3_i == F_DIV) || (funct3_i == F_REM)) &&
                   (opa_i == INT_MIN) && (opb_i == ALL_ONES)) begin
        // Signed overflow: quotient wraps to INT_MIN, remainder is zero
        hit_o   = 1'b1;
        value_o = (funct3_i == F_DIV) ? INT_MIN : '0;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage. Works on operand
// magnitudes one bit per cycle (shift-add multiply, restoring divide), then
// applies the sign correction in a single fixup cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e            state_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   a_q;        // multiplicand, or dividend shifting into quotient
  logic [XLEN-1:0]   b_q;        // multiplier (shifts right), or divisor
  logic [2*XLEN-1:0] acc_q;      // product, or remainder in the upper half
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q;      // final result must be negated
  logic [XLEN-1:0]   result_q;
  logic              done_q;

  logic              sp_hit;
  logic [XLEN-1:0]   sp_value;
  logic              a_neg, b_neg, start_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN-1:0]   div_sub;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem_next;
  logic [2*XLEN-1:0] acc_fixed;
  logic [XLEN-1:0]   quo_fixed, rem_fixed;
  logic [XLEN-1:0]   fix_result;

  muldiv_special u_special (
    .funct3_i (funct3),
    .opa_i    (opa),
    .opb_i    (opb),
    .hit_o    (sp_hit),
    .value_o  (sp_value)
  );

  // Operand magnitudes and result sign captured at start
  always_comb begin
    a_neg     = is_signed_a(funct3) & opa[XLEN-1];
    b_neg     = is_signed_b(funct3) & opb[XLEN-1];
    a_mag     = a_neg ? -opa : opa;
    b_mag     = b_neg ? -opb : opb;
    // Remainder follows the dividend; products and quotients follow the sign XOR
    start_neg = (funct3 == F_REM) ? a_neg : (a_neg ^ b_neg);
  end

  // One iteration step: shift-add multiply and restoring divide
  always_comb begin
    mul_sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : '0);
    mul_acc_next = {mul_sum, acc_q[XLEN-1:1]};
    div_shift    = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
    div_ge       = div_shift >= {1'b0, b_q};
    div_sub      = div_shift[XLEN-1:0] - b_q;
    div_rem_next = div_ge ? div_sub : div_shift[XLEN-1:0];
  end

  // Sign fixup and result-half selection used in the FIX state
  always_comb begin
    acc_fixed = neg_q ? -acc_q : acc_q;
    quo_fixed = neg_q ? -a_q : a_q;
    rem_fixed = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    unique case (f3_q)
      F_MUL:                  fix_result = acc_fixed[XLEN-1:0];
      F_MULH, F_MULHSU,
      F_MULHU:                fix_result = acc_fixed[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:          fix_result = quo_fixed;
      default:                fix_result = rem_fixed;
    endcase
  end

  // Main FSM with datapath registers; rst beats kill beats start
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (kill) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (sp_hit) begin
              result_q <= sp_value;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              f3_q    <= funct3;
              a_q     <= a_mag;
              b_q     <= b_mag;
              neg_q   <= start_neg;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (f3_q[2]) begin
            acc_q[2*XLEN-1:XLEN] <= div_rem_next;
            a_q                  <= {a_q[XLEN-2:0], div_ge};
          end else begin
            acc_q <= mul_acc_next;
            b_q   <= b_q >> 1;
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          result_q <= fix_result;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Stall request: iterating, or accepting a new op this cycle
  always_comb begin
    busy = (state_q == S_CALC) || (state_q == S_FIX) ||
           ((state_q == S_IDLE) && start && !kill);
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: table of ops with hand-computed results and
// timing, followed by kill, reset and back-to-back sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  funct3;
  logic [31:0] opa, opb;
  logic        busy, done;
  logic [31:0] result;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .kill   (kill),
    .funct3 (funct3),
    .opa    (opa),
    .opb    (opb),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after DONE
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit special);
    int          lat;
    int          bcnt;
    logic [31:0] res;
    logic        busy_at_done;
    funct3 = f; opa = a; opb = b; start = 1'b1;
    #1;
    bcnt = busy ? 1 : 0;
    @(posedge clk); #1;
    start = 1'b0; opa = $urandom; opb = $urandom; funct3 = 3'($urandom);
    lat = -1; res = 'x; busy_at_done = 1'bx;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        lat = k; res = result; busy_at_done = busy;
        break;
      end
      if (busy) bcnt++;
      @(posedge clk); #1;
    end
    check({name, " result"}, res, exp);
    check({name, " latency"}, 32'(lat), special ? 32'd0 : 32'd33);
    check({name, " busy cycles"}, 32'(bcnt), special ? 32'd1 : 32'd34);
    check({name, " busy in done cycle"}, {31'd0, busy_at_done}, 32'd0);
    @(posedge clk); #1;
    check({name, " single done pulse"}, {31'd0, done}, 32'd0);
    $display("op %-14s f3=%0d a=0x%08h b=0x%08h result=0x%08h latency=%0d busy=%0d",
             name, f, a, b, res, lat, bcnt);
  endtask

  initial begin
    vecs[0]  = '{"MUL 7*-3",       F_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{"MULH 7*-3",      F_MULH,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{"MULHU max*max",  F_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[3]  = '{"MULHSU -1*2",    F_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{"DIV -7/2",       F_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{"REM -7/2",       F_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{"DIVU 100/7",     F_DIVU,   32'd100,        32'd7,         32'd14,        1'b0};
    vecs[7]  = '{"REMU 100/7",     F_REMU,   32'd100,        32'd7,         32'd2,         1'b0};
    vecs[8]  = '{"DIVU 5/0",       F_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{"REM 5/0",        F_REM,    32'd5,          32'd0,         32'd5,         1'b1};
    vecs[10] = '{"DIV ovf",        F_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[11] = '{"REM ovf",        F_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1};
    vecs[12] = '{"MUL wide",       F_MUL,    32'h1234_5678,  32'h0000_0010, 32'h2345_6780, 1'b0};
    vecs[13] = '{"MULH min*min",   F_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[14] = '{"REM 7/-2",       F_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         1'b0};
    vecs[15] = '{"DIVU max/1",     F_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 1'b0};

    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset result", result, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].special);
    end

    // start together with kill in IDLE: no stall, op not accepted
    funct3 = F_MUL; opa = 32'd2; opb = 32'd2; start = 1'b1; kill = 1'b1;
    #1;
    check("start+kill busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    check("start+kill stays idle", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // kill at counter 10: back to IDLE, result kept, then an immediate new op
    funct3 = F_MUL; opa = 32'd9; opb = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int seen_done = 0;
      repeat (10) begin
        @(posedge clk); #1;
        if (done) seen_done++;
      end
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      if (done) seen_done++;
      check("kill no done", 32'(seen_done), 32'd0);
      check("kill idle busy", {31'd0, busy}, 32'd0);
      check("kill keeps result", result, 32'hFFFF_FFFF);
    end
    run_op("MUL 3*4 post-kill", F_MUL, 32'd3, 32'd4, 32'd12, 1'b0);

    // reset mid-CALC
    funct3 = F_MUL; opa = 32'd5; opb = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid-calc reset busy", {31'd0, busy}, 32'd0);
    check("mid-calc reset done", {31'd0, done}, 32'd0);
    check("mid-calc reset result", result, 32'd0);
    @(posedge clk); #1;
    check("post-reset idle done", {31'd0, done}, 32'd0);

    // back-to-back ops
    run_op("DIVU 9/3 b2b", F_DIVU, 32'd9, 32'd3, 32'd3, 1'b0);
    run_op("MUL 5*5 b2b", F_MUL, 32'd5, 32'd5, 32'd25, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit that sits in the execute stage beside the ALU.
- Takes forwarded operands from the ID/EX register and stalls the front of the pipeline while it iterates.
- Presents a 32-bit result that the EX/ME register captures in the cycle `done` is high.
- Covers all eight RV32M ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), selected by funct3.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  EX stage holds a valid M-extension op; sampled only in IDLE.
- kill  input  1  flush: abort the in-flight operation (branch/jump taken later in the pipe).
- funct3  input  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- opa  input  XLEN  rs1 value (already forwarded).
- opb  input  XLEN  rs2 value (already forwarded).
- busy  output  1  stall request to IF/ID and ID/EX enables.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  registered result; holds its value until the next completion.

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset (rst=1 at edge): state IDLE, result 0, done 0, counter 0, internal accumulators 0.
- Priority at each edge: rst > kill > start.
- kill in any state: next state IDLE; result unchanged; no done pulse.
- IDLE:
  - start=1 with a normal op: latch funct3 and operand magnitudes. Signed ops take absolute values; MULHSU takes opb unsigned. Record the result sign, clear the 64-bit accumulator, counter=0, go to CALC.
  - start=1 with a special case: load result directly and go to DONE. Special cases:
    - divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give opa.
    - signed overflow (opa=0x80000000, opb=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC: one bit per cycle, 32 cycles (counter 0..31); at counter=31 go to FIX.
  - Multiply: shift-add into the 64-bit product.
  - Divide: restoring, 1 quotient bit per cycle.
- FIX: apply sign correction, select the result half, register result, go to DONE.
  - Product: negate if the operand signs differ.
  - Quotient: negate if signs differ.
  - Remainder: takes the sign of the dividend.
  - MUL returns the low word; MULH/MULHSU/MULHU return the high word.
- DONE: done=1 for exactly this cycle; start ignored; next state IDLE.
- Latency, start sampled at edge E0:
  - Normal op: done high in the cycle after edge E33.
  - Special case: done high in the cycle after E0.
- busy (combinational) = (state==CALC) | (state==FIX) | (state==IDLE & start & ~kill).
  - busy=0 in DONE, so the pipeline advances and EX/ME latches result on that edge.
- Back-to-back ops: the next M op reaches EX the cycle after DONE, finds IDLE, and starts normally.
- start while in CALC/FIX/DONE is ignored.
- Operands are latched at start; changes on opa/opb during CALC have no effect.
- All arithmetic is modulo 2^64 internally; the result is truncated to XLEN.

Decomposition:
- Package muldiv_pkg holds:
  - funct3 localparams (F_MUL..F_REMU).
  - State encodings (S_IDLE=2'd0, S_CALC=2'd1, S_FIX=2'd2, S_DONE=2'd3).
  - Constants ALL_ONES=32'hFFFFFFFF and INT_MIN=32'h80000000.
- One natural sub-module: muldiv_special, combinational. It detects divide-by-zero and overflow and outputs the special result plus a hit flag.
- The FSM, datapath and sign fixup stay in muldiv_unit.

Test Plan:
- MUL opa=7, opb=-3 (0xFFFFFFFD), start one cycle -> busy high 34 cycles (start cycle through FIX), done once, result 0xFFFFFFEB. MULH of the same operands -> 0xFFFFFFFF.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU opa=-1, opb=2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each takes the same 34-cycle timing.
- Special cases, each with done in the cycle after start and busy high for 1 cycle:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
- kill asserted at CALC counter=10 -> IDLE next cycle, no done, result keeps its prior value; an immediate new start (MUL 3×4) completes with 12.
- rst asserted mid-CALC -> state IDLE, result 0, done 0 on the next edge. Back-to-back DIVU 9/3 then MUL 5×5 -> two done pulses, results 3 then 25, with no lost or duplicated ops.
